// File: rtl/ggt_engine.sv
// Iterative GCD (ggT) engine: Euclidean loop where each remainder is computed
// by a restoring shift-subtract divider, one quotient bit per clock.
module ggt_engine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic [WIDTH-1:0] ergebnis,
    output logic             valid
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ergebnis_q, ergebnis_d;
    logic             valid_q, valid_d;

    // Partial remainder widened by one bit so the compare never overflows
    logic [WIDTH:0]   t_c;
    logic [WIDTH:0]   b_ext_c;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        q_d        = q_q;
        count_d    = count_q;
        ergebnis_d = ergebnis_q;
        valid_d    = valid_q;
        t_c        = {r_q, q_q[WIDTH-1]};
        b_ext_c    = {1'b0, b_q};

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = Zahl1_i;
                    b_d     = Zahl2_i;
                    valid_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (b_q == '0) begin
                    ergebnis_d = a_q;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    r_d     = '0;
                    q_d     = a_q;
                    count_d = CW'(WIDTH);
                    state_d = DIV;
                end
            end
            DIV: begin
                q_d = q_q << 1;
                if (t_c >= b_ext_c) begin
                    r_d = WIDTH'(t_c - b_ext_c);
                end else begin
                    r_d = t_c[WIDTH-1:0];
                end
                count_d = count_q - CW'(1);
                // Last quotient bit: divisor becomes dividend, remainder becomes divisor
                if (count_q == CW'(1)) begin
                    a_d     = b_q;
                    b_d     = r_d;
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            count_q    <= '0;
            ergebnis_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            q_q        <= q_d;
            count_q    <= count_d;
            ergebnis_q <= ergebnis_d;
            valid_q    <= valid_d;
        end
    end

    assign ergebnis = ergebnis_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_ggt_engine.sv
// Scoreboard bench for ggt_engine: the driver queues expected result and cycle of
// valid rise per run; a monitor pops on each valid rising edge and compares.
module tb_ggt_engine;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [W-1:0] Zahl1_i;
    logic [W-1:0] Zahl2_i;
    logic [W-1:0] ergebnis;
    logic         valid;

    ggt_engine #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .Zahl1_i  (Zahl1_i),
        .Zahl2_i  (Zahl2_i),
        .ergebnis (ergebnis),
        .valid    (valid)
    );

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic         vprev  = 1'b0;
    logic [W-1:0] cur_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: match each valid rise against the oldest expectation, then watch stability
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid && !vprev) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: ergebnis=%0d at cycle %0d, no result expected", ergebnis, cyc);
                end else begin
                    e = sb.pop_front();
                    if (ergebnis !== e.res) begin
                        n_fail++;
                        $display("FAIL result: got %0d, expected %0d", ergebnis, e.res);
                    end
                    n_chk++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL latency: valid rose at cycle %0d, expected %0d", cyc, e.cyc);
                    end
                    cur_res = e.res;
                end
            end else if (valid) begin
                n_chk++;
                if (ergebnis !== cur_res) begin
                    n_fail++;
                    $display("FAIL stable: ergebnis=%0d while valid, expected %0d", ergebnis, cur_res);
                end
            end
        end
        vprev = valid;
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Issue one start from IDLE; lat = cycles from start edge to valid rise
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input int lat, input bit expect_res);
        exp_t e;
        @(negedge clk);
        Zahl1_i = a;
        Zahl2_i = b;
        start_i = 1'b1;
        if (expect_res) begin
            e.res = res;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
        Zahl1_i = 16'hA5A5;
        Zahl2_i = 16'h0003;
        check("valid_drop_on_start", W'(valid), '0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        Zahl1_i = '0;
        Zahl2_i = '0;
        #1;
        check("reset_ergebnis", ergebnis, '0);
        check("reset_valid", W'(valid), '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run(16'd48, 16'd18, 16'd6, 52, 1'b1);        wait_done();
        run(16'd0, 16'd0, 16'd0, 1, 1'b1);           wait_done();
        run(16'd65535, 16'd0, 16'd65535, 1, 1'b1);   wait_done();
        run(16'd0, 16'd7, 16'd7, 18, 1'b1);          wait_done();
        run(16'd65535, 16'd65534, 16'd1, 35, 1'b1);  wait_done();
        run(16'd1071, 16'd462, 16'd21, 52, 1'b1);    wait_done();
        run(16'd18, 16'd48, 16'd6, 69, 1'b1);        wait_done();

        // start pulse while dividing must be ignored
        run(16'd12, 16'd8, 16'd4, 35, 1'b1);
        repeat (5) @(negedge clk);
        Zahl1_i = 16'd9;
        Zahl2_i = 16'd3;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done();
        run(16'd9, 16'd3, 16'd3, 18, 1'b1);          wait_done();

        // asynchronous reset in the middle of a division
        run(16'd48, 16'd18, 16'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_ergebnis", ergebnis, '0);
        check("midrun_rst_valid", W'(valid), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", W'(valid), '0);
        run(16'd48, 16'd18, 16'd6, 52, 1'b1);        wait_done();

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
